// File: rtl/bus_pkg.sv
// Shared encodings for the BRAM-bus initiator: element sizes, byte enables,
// address increments and the copy-engine state enum.
package bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_REL,
        WR_REQ,
        WR_REL,
        ERR_REL,
        FIN
    } state_e;

    function automatic logic [3:0] size_be(input size_e sz);
        case (sz)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_inc(input size_e sz);
        case (sz)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input size_e sz, input logic [31:0] d);
        case (sz)
            SIZE_BYTE: return {24'h0, d[7:0]};
            SIZE_HALF: return {16'h0, d[15:0]};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/bus_init_port.sv
// One four-phase bus access: decodes ready/err against the current phase and
// runs the per-phase timeout counter.
module bus_init_port #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic rel,
    input  logic clear,
    input  logic bus_ready,
    input  logic bus_err,
    output logic ack,
    output logic ack_err,
    output logic released,
    output logic timeout
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] timer;
    logic          active;

    assign active   = req | rel;
    assign ack      = req & bus_ready;
    assign ack_err  = req & bus_ready & bus_err;
    assign released = rel & ~bus_ready;
    // Fires on the TIMEOUT-th cycle spent in the same phase.
    assign timeout  = (TIMEOUT != 0) && active && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clear || !active) begin
            timer <= '0;
        end else if (TIMEOUT != 0 && !timeout) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/bus_dma_copy.sv
// Bus initiator copying COUNT byte/half/word elements from src to dst, one
// four-phase read then one four-phase write per element.
module bus_dma_copy
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [1:0]            size,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  bus_enable,
    output logic                  bus_wr_en,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_o_data,
    output logic [3:0]            bus_be,
    input  logic [DATA_WIDTH-1:0] bus_i_data,
    input  logic                  bus_ready,
    input  logic                  bus_err
);

    state_e                state, state_next;
    logic [ADDR_WIDTH-1:0] src, dst, err_addr_next;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] data_q;
    size_e                 size_q;
    logic                  accept, capture, advance, set_err;
    logic                  in_req, in_rel, ack, ack_err, released, timeout;

    assign in_req = (state == RD_REQ) || (state == WR_REQ);
    assign in_rel = (state == RD_REL) || (state == WR_REL) || (state == ERR_REL);

    bus_init_port #(.TIMEOUT(TIMEOUT)) u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (in_req),
        .rel      (in_rel),
        .clear    (state_next != state),
        .bus_ready(bus_ready),
        .bus_err  (bus_err),
        .ack      (ack),
        .ack_err  (ack_err),
        .released (released),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            size_q    <= SIZE_BYTE;
            data_q    <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                src       <= src_addr;
                dst       <= dst_addr;
                remaining <= count;
                size_q    <= size_e'(size);
                err       <= 1'b0;
                err_addr  <= '0;
            end
            // set_err after accept so a reserved size reports on the same start
            if (set_err) begin
                err      <= 1'b1;
                err_addr <= err_addr_next;
            end
            if (capture) data_q <= size_mask(size_q, bus_i_data);
            if (advance) begin
                src       <= src + ADDR_WIDTH'(size_inc(size_q));
                dst       <= dst + ADDR_WIDTH'(size_inc(size_q));
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        capture       = 1'b0;
        advance       = 1'b0;
        set_err       = 1'b0;
        err_addr_next = err_addr;
        case (state)
            IDLE: if (start) begin
                accept = 1'b1;
                if (count == '0) begin
                    state_next = FIN;
                end else if (size_e'(size) == SIZE_RSVD) begin
                    set_err       = 1'b1;
                    err_addr_next = '0;
                    state_next    = FIN;
                end else begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                if (ack) begin
                    if (ack_err) begin
                        set_err       = 1'b1;
                        err_addr_next = bus_addr;
                        state_next    = ERR_REL;
                    end else begin
                        capture    = (state == RD_REQ);
                        state_next = (state == RD_REQ) ? RD_REL : WR_REL;
                    end
                end else if (timeout) begin
                    set_err       = 1'b1;
                    err_addr_next = bus_addr;
                    state_next    = FIN;
                end
            end
            RD_REL, WR_REL: begin
                if (released) begin
                    if (state == RD_REL) begin
                        state_next = WR_REQ;
                    end else begin
                        advance    = 1'b1;
                        state_next = (remaining == CNT_WIDTH'(1)) ? FIN : RD_REQ;
                    end
                end else if (timeout) begin
                    set_err       = 1'b1;
                    err_addr_next = bus_addr;
                    state_next    = FIN;
                end
            end
            ERR_REL: if (released || timeout) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE) && (state != FIN);
        done       = (state == FIN);
        bus_enable = in_req;
        bus_wr_en  = (state == WR_REQ);
        bus_be     = in_req ? size_be(size_q) : 4'b0000;
        bus_o_data = (state == WR_REQ) ? data_q : '0;
        bus_addr   = '0;
        if (state == RD_REQ || state == RD_REL) bus_addr = src;
        if (state == WR_REQ || state == WR_REL) bus_addr = dst;
    end

endmodule
